// File: rtl/cmod_s7_button.sv
// cmod_s7_button: push-button conditioner for the Cmod S7 board.
// Each button goes through a 2-FF synchronizer and then a four-state debounce FSM.
// The FSM produces a stable level plus single-cycle press and release strobes.
// Optional long-press strobe: define CMOD_S7_BTN_LONG_PRESS_EN to build it.
// Without the macro, btn_long_o is tied to 0.
module cmod_s7_button #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int DEBOUNCE_US   = 10_000,
    parameter int NUM_BTN       = 2,
    parameter int LONG_PRESS_US = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] btn_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic [NUM_BTN-1:0] btn_release_o,
    output logic [NUM_BTN-1:0] btn_long_o
);

    localparam int DB_CYC = CLK_FREQ / 1_000_000 * DEBOUNCE_US;
    localparam int LP_CYC = CLK_FREQ / 1_000_000 * LONG_PRESS_US;
    localparam int CW     = $clog2(DB_CYC + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYC - 1);

    // Reject parameter sets that make the debounce or hold windows meaningless.
    if (DB_CYC < 2) begin : g_bad_db
        $error("cmod_s7_button: DB_CYC must be at least 2");
    end
    if (LP_CYC < 1) begin : g_bad_lp
        $error("cmod_s7_button: LP_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_PEND_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_PEND_LO   = 2'd3
    } btn_state_t;

    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    btn_state_t         r_state [NUM_BTN];
    logic [CW-1:0]      r_cnt   [NUM_BTN];
    logic [NUM_BTN-1:0] r_btn;
    logic [NUM_BTN-1:0] r_press;
    logic [NUM_BTN-1:0] r_release;

    // Two-flop synchronizer: nothing downstream ever looks at btn_i directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            // NOTE: sequential state uses <= so both flops sample pre-edge values.
            r_sync1 <= btn_i;
            r_sync2 <= r_sync1;
        end
    end

    // Per-button debounce FSM: DB_CYC consecutive samples of a new level accept it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the small state/counter arrays are flops, not RAM, so resetting them is cheap and intended.
            for (int i = 0; i < NUM_BTN; i++) begin
                r_state[i] <= ST_STABLE_LO;
                r_cnt[i]   <= '0;
            end
            r_btn     <= '0;
            r_press   <= '0;
            r_release <= '0;
        end else begin
            // NOTE: strobes default low every cycle; a later bit assignment in the loop overrides this.
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                case (r_state[i])
                    ST_STABLE_LO: begin
                        if (r_sync2[i]) begin
                            r_state[i] <= ST_PEND_HI;
                            r_cnt[i]   <= CW'(1);
                        end else begin
                            r_cnt[i]   <= '0;
                        end
                    end
                    ST_PEND_HI: begin
                        if (!r_sync2[i]) begin
                            r_state[i] <= ST_STABLE_LO;
                            r_cnt[i]   <= '0;
                        end else if (r_cnt[i] == DB_LAST) begin
                            r_state[i] <= ST_STABLE_HI;
                            r_cnt[i]   <= '0;
                            r_btn[i]   <= 1'b1;
                            r_press[i] <= 1'b1;
                        end else begin
                            r_cnt[i]   <= r_cnt[i] + CW'(1);
                        end
                    end
                    ST_STABLE_HI: begin
                        if (!r_sync2[i]) begin
                            r_state[i] <= ST_PEND_LO;
                            r_cnt[i]   <= CW'(1);
                        end else begin
                            r_cnt[i]   <= '0;
                        end
                    end
                    ST_PEND_LO: begin
                        if (r_sync2[i]) begin
                            r_state[i] <= ST_STABLE_HI;
                            r_cnt[i]   <= '0;
                        end else if (r_cnt[i] == DB_LAST) begin
                            r_state[i]   <= ST_STABLE_LO;
                            r_cnt[i]     <= '0;
                            r_btn[i]     <= 1'b0;
                            r_release[i] <= 1'b1;
                        end else begin
                            r_cnt[i]     <= r_cnt[i] + CW'(1);
                        end
                    end
                    default: begin
                        r_state[i] <= ST_STABLE_LO;
                        r_cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_o         = r_btn;
    assign btn_press_o   = r_press;
    assign btn_release_o = r_release;

`ifdef CMOD_S7_BTN_LONG_PRESS_EN
    localparam int LW = $clog2(LP_CYC + 1);
    localparam logic [LW-1:0] LP_MAX  = LW'(LP_CYC);
    localparam logic [LW-1:0] LP_LAST = LW'(LP_CYC - 1);

    logic [LW-1:0]      r_hold [NUM_BTN];
    logic [NUM_BTN-1:0] r_long;

    // Hold timer: counts cycles since the press strobe, fires once at LP_CYC, then saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_hold[i] <= '0;
            end
            r_long <= '0;
        end else begin
            r_long <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (!r_btn[i]) begin
                    r_hold[i] <= '0;
                end else if (r_hold[i] != LP_MAX) begin
                    r_hold[i] <= r_hold[i] + LW'(1);
                    if (r_hold[i] == LP_LAST) begin
                        r_long[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign btn_long_o = r_long;
`else
    assign btn_long_o = '0;
`endif

endmodule
